pipe_stage_buf: RTL

Parametrised pipeline-stage register that succeeds the fixed-field stage registers between decode, execute, memory and write-back. It carries one payload bus and one control bus through a 2-entry skid buffer with a valid/ready handshake. The handshake gives full throughput with a registered `in_ready`. Flush inserts bubbles, and invalid slots always present a programmable NOP control word, so stall and flush handling lives in the stage register rather than in hazard logic.

---
 rtl/pipe_stage_buf.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register built as a 2-entry skid buffer with a registered in_ready.
// Invalid output slots present BUBBLE_CTRL; flush turns all held entries into bubbles.
module pipe_stage_buf #(
    parameter int                DATA_W      = 128,
    parameter int                CTRL_W      = 13,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // Buffer state is {skid_valid, main_valid}; 2'b10 is unreachable.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_MAIN  = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic              main_valid;
    logic              skid_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic              accept;
    logic              pop;
    logic              main_valid_nxt;
    logic              skid_valid_nxt;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    function automatic logic [CTRL_W-1:0] mask_ctrl(input logic valid,
                                                    input logic [CTRL_W-1:0] ctrl);
        return valid ? ctrl : BUBBLE_CTRL;
    endfunction

    function automatic logic [1:0] count_entries(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // in_ready depends only on held state; rst masks it so nothing is offered during reset.
    assign in_ready  = !skid_valid && !rst;
    assign out_valid = main_valid;
    assign accept    = in_valid && in_ready;
    assign pop       = main_valid && out_ready;

    always_comb begin
        main_valid_nxt = main_valid;
        skid_valid_nxt = skid_valid;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            main_valid_nxt = 1'b0;
            skid_valid_nxt = 1'b0;
        end else begin
            case ({skid_valid, main_valid})
                ST_EMPTY: begin
                    if (accept) begin
                        load_main_in   = 1'b1;
                        main_valid_nxt = 1'b1;
                    end
                end
                ST_MAIN: begin
                    if (pop && accept) begin
                        load_main_in = 1'b1;
                    end else if (pop) begin
                        main_valid_nxt = 1'b0;
                    end else if (accept) begin
                        load_skid      = 1'b1;
                        skid_valid_nxt = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        load_main_skid = 1'b1;
                        skid_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    skid_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            main_valid <= main_valid_nxt;
            skid_valid <= skid_valid_nxt;
        end
    end

    // Head payload is cleared on reset so out_data reads zero; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_data <= '0;
            main_ctrl <= BUBBLE_CTRL;
        end else if (load_main_in) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
        end else if (load_main_skid) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
        end
    end

    assign out_data  = main_data;
    assign out_ctrl  = mask_ctrl(main_valid, main_ctrl);
    assign occupancy = count_entries(main_valid, skid_valid);

endmodule
